// File: rtl/ddr_rx_test_sequencer.sv
// DDR-input throughput test sequencer.
// Locks onto an incrementing rise/fall nibble pattern, then checks a
// fixed-length window of cycles and counts the cycles that break the pattern.
module ddr_rx_test_sequencer #(
  parameter int DW           = 4,
  parameter int CNT_W        = 16,
  parameter int LOCK_CYCLES  = 8,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       len_sel,
  input  logic [DW-1:0]    rise_d,
  input  logic [DW-1:0]    fall_d,
  output logic             busy,
  output logic             done,
  output logic             locked,
  output logic             err_sat,
  output logic [CNT_W-1:0] err_count
);

  localparam int GR_W = $clog2(LOCK_CYCLES + 1);
  localparam int LT_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [DW-1:0]   last_fall;
  logic [GR_W-1:0] good_run;
  logic [LT_W-1:0] lock_cnt;
  logic [13:0]     cyc_cnt;
  logic [1:0]      len_r;

  logic [DW-1:0]    rise_exp;
  logic [DW-1:0]    fall_exp;
  logic             clean;
  logic [GR_W-1:0]  good_run_nxt;
  logic [LT_W-1:0]  lock_cnt_nxt;
  logic [13:0]      last_cyc;
  logic [CNT_W-1:0] err_inc;
  logic             err_at_max;

  // Pattern check and next-value helpers for the sequencer
  always_comb begin
    rise_exp     = last_fall + 1'b1;
    fall_exp     = rise_d + 1'b1;
    clean        = (fall_d == fall_exp) && (rise_d == rise_exp);
    good_run_nxt = clean ? good_run + 1'b1 : '0;
    lock_cnt_nxt = lock_cnt + 1'b1;
    err_at_max   = (err_count == '1);
    err_inc      = err_count + 1'b1;
    case (len_r)
      2'd0:    last_cyc = 14'd255;
      2'd1:    last_cyc = 14'd1023;
      2'd2:    last_cyc = 14'd4095;
      default: last_cyc = 14'd16383;
    endcase
  end

  // Main sequencer: state, counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_fall <= '0;
      good_run  <= '0;
      lock_cnt  <= '0;
      cyc_cnt   <= '0;
      len_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      locked    <= 1'b0;
      err_sat   <= 1'b0;
      err_count <= '0;
    end else if (abort || !ena) begin
      state     <= IDLE;
      good_run  <= '0;
      lock_cnt  <= '0;
      cyc_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      locked    <= 1'b0;
      err_sat   <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOCK;
            last_fall <= fall_d;
            len_r     <= len_sel;
            good_run  <= '0;
            lock_cnt  <= '0;
            cyc_cnt   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            locked    <= 1'b0;
            err_sat   <= 1'b0;
            err_count <= '0;
          end
        end
        LOCK: begin
          last_fall <= fall_d;
          good_run  <= good_run_nxt;
          lock_cnt  <= lock_cnt_nxt;
          // Lock wins over a timeout landing on the same cycle
          if (good_run_nxt == GR_W'(LOCK_CYCLES)) begin
            state   <= RUN;
            locked  <= 1'b1;
            cyc_cnt <= '0;
          end else if (lock_cnt_nxt == LT_W'(LOCK_TIMEOUT)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        RUN: begin
          last_fall <= fall_d;
          cyc_cnt   <= cyc_cnt + 1'b1;
          if (!clean) begin
            if (err_at_max) begin
              err_sat <= 1'b1;
            end else begin
              err_count <= err_inc;
              if (err_inc == '1) err_sat <= 1'b1;
            end
          end
          if (cyc_cnt == last_cyc) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
